// File: rtl/jtframe_inputs_rec.sv
// Per-frame game input recorder.
// Samples coin/start/joy1 once per frame on the falling edge of LVBL and stores
// each sample active-high in block RAM. A valid/ready stream dumps the recording
// to the host, using a prefetch register so it can sustain one word per clock.

module jtframe_inputs_rec #(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned AW         = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          downloading,
    input  logic          rec_en,
    input  logic [3:0]    game_coin,
    input  logic [3:0]    game_start,
    input  logic [9:0]    game_joy1,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [15:0]   dump_data,
    output logic          dump_last,
    output logic          rec_active,
    output logic          full,
    output logic          overflow,
    output logic [AW:0]   frames
);

    localparam logic [AW:0] Cap = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] One = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRec, StFull, StDump} state_t;

    state_t       state_q, state_d;
    logic         lvbl_l_q;
    logic         fe;
    logic [AW:0]  frames_q, frames_d;
    logic         overflow_q, overflow_d;
    // Set when a dump is launched from FULL; blocks re-recording until rec_en drops
    logic         rec_block_q, rec_block_d;

    logic         we;
    logic [15:0]  word;
    logic [3:0]   coin_h, start_h;
    logic [9:0]   joy_h;
    logic         unused_bits;

    // Dump pipeline: RAM output register acts as the prefetch stage
    logic         re;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]  rdata_q;
    logic         pf_valid_q, pf_valid_d;
    logic         pf_last_q, pf_last_d;
    logic         out_valid_q, out_valid_d;
    logic [15:0]  out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic         fire;
    logic         move;

    logic [15:0]  mem [2**AW];

    assign fe = lvbl_l_q & ~LVBL;

    assign coin_h  = game_coin  ^ {4{ACTIVE_LOW}};
    assign start_h = game_start ^ {4{ACTIVE_LOW}};
    assign joy_h   = game_joy1  ^ {10{ACTIVE_LOW}};
    assign word    = {6'b0, joy_h[5:0], start_h[1:0], coin_h[1:0]};
    assign unused_bits = ^{coin_h[3:2], start_h[3:2], joy_h[9:6]};

    assign fire = out_valid_q & dump_ready;
    assign move = pf_valid_q & (~out_valid_q | fire);

    // Next-state, recording and dump pipeline control
    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        overflow_d  = overflow_q;
        rec_block_d = rec_block_q & rec_en;
        we          = 1'b0;
        re          = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        pf_valid_d  = pf_valid_q;
        pf_last_d   = pf_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            StIdle: begin
                if (rec_en && !downloading && !rec_block_q) begin
                    state_d    = StRec;
                    frames_d   = '0;
                    overflow_d = 1'b0;
                end else if (dump_start && frames_q != '0) begin
                    state_d  = StDump;
                    rd_ptr_d = '0;
                end
            end
            StRec: begin
                // A frame edge coinciding with the exit is still written
                if (fe) begin
                    we       = 1'b1;
                    frames_d = frames_q + One;
                end
                if (!rec_en || downloading) begin
                    state_d = StIdle;
                end else if (fe && frames_q == Cap - One) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (fe) overflow_d = 1'b1;
                if (dump_start) begin
                    state_d     = StDump;
                    rd_ptr_d    = '0;
                    rec_block_d = 1'b1;
                end else if (!rec_en) begin
                    state_d = StIdle;
                end
            end
            StDump: begin
                if (move) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rdata_q;
                    out_last_d  = pf_last_q;
                end else if (fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                // Refill the prefetch stage whenever it is empty or being drained
                if ((!pf_valid_q || move) && rd_ptr_q != frames_q) begin
                    re         = 1'b1;
                    rd_ptr_d   = rd_ptr_q + One;
                    pf_valid_d = 1'b1;
                    pf_last_d  = (rd_ptr_q == frames_q - One);
                end else if (move) begin
                    pf_valid_d = 1'b0;
                    pf_last_d  = 1'b0;
                end
                if (fire && out_last_q) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lvbl_l_q    <= 1'b0;
            frames_q    <= '0;
            overflow_q  <= 1'b0;
            rec_block_q <= 1'b0;
            rd_ptr_q    <= '0;
            pf_valid_q  <= 1'b0;
            pf_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvbl_l_q    <= LVBL;
            frames_q    <= frames_d;
            overflow_q  <= overflow_d;
            rec_block_q <= rec_block_d;
            rd_ptr_q    <= rd_ptr_d;
            pf_valid_q  <= pf_valid_d;
            pf_last_q   <= pf_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Recording RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[frames_q[AW-1:0]] <= word;
    end

    // Recording RAM read port; holds its word while the prefetch stage is full
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem[rd_ptr_q[AW-1:0]];
    end

    assign dump_valid = out_valid_q;
    assign dump_data  = out_data_q;
    assign dump_last  = out_last_q;
    assign rec_active = (state_q == StRec);
    assign full       = (state_q == StFull);
    assign overflow   = overflow_q;
    assign frames     = frames_q;

endmodule

// File: tb/tb_jtframe_inputs_rec.sv
// Scoreboard bench for jtframe_inputs_rec: recorded frames are kept in a queue
// model, dumps push the expected stream, and a monitor checks every transfer.

module tb_jtframe_inputs_rec;

    localparam int unsigned AW  = 3;
    localparam int          Cap = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          LVBL;
    logic          downloading;
    logic          rec_en;
    logic [3:0]    game_coin;
    logic [3:0]    game_start;
    logic [9:0]    game_joy1;
    logic          dump_start;
    logic          dump_ready;
    logic          dump_valid;
    logic [15:0]   dump_data;
    logic          dump_last;
    logic          rec_active;
    logic          full;
    logic          overflow;
    logic [AW:0]   frames;

    jtframe_inputs_rec #(
        .ACTIVE_LOW (1'b1),
        .AW         (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .LVBL        (LVBL),
        .downloading (downloading),
        .rec_en      (rec_en),
        .game_coin   (game_coin),
        .game_start  (game_start),
        .game_joy1   (game_joy1),
        .dump_start  (dump_start),
        .dump_ready  (dump_ready),
        .dump_valid  (dump_valid),
        .dump_data   (dump_data),
        .dump_last   (dump_last),
        .rec_active  (rec_active),
        .full        (full),
        .overflow    (overflow),
        .frames      (frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;
    logic [15:0] model_mem [$];
    bit          model_ovf;
    exp_t        exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Active-low inputs become an active-high word: coin[1:0], start[1:0], joy[5:0]
    function automatic logic [15:0] model_word(input logic [3:0] c, input logic [3:0] s,
                                               input logic [9:0] j);
        logic [3:0] ch;
        logic [3:0] sh;
        logic [9:0] jh;
        ch = ~c;
        sh = ~s;
        jh = ~j;
        return {6'b0, jh[5:0], sh[1:0], ch[1:0]};
    endfunction

    task automatic junk_inputs();
        game_coin  = 4'($urandom);
        game_start = 4'($urandom);
        game_joy1  = 10'($urandom);
    endtask

    // Monitor: checks each transfer against the scoreboard and stall stability
    logic [15:0] held_data;
    logic        held_last;
    bit          stalled = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_valid", {31'b0, dump_valid}, 32'd1);
                chk("stall_data", {16'b0, dump_data}, {16'b0, held_data});
                chk("stall_last", {31'b0, dump_last}, {31'b0, held_last});
            end
            stalled = 0;
            if (dump_valid && dump_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", dump_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dump_data", {16'b0, dump_data}, {16'b0, e.data});
                    chk("dump_last", {31'b0, dump_last}, {31'b0, e.last});
                end
            end else if (dump_valid) begin
                stalled   = 1;
                held_data = dump_data;
                held_last = dump_last;
            end
        end
    end

    // Enter REC, produce n LVBL falls, optionally leave rec_en high afterwards
    task automatic record(input int n, input bit fixed, input bit keep_en);
        logic [15:0] w;
        rec_en = 1'b1;
        tick(2);
        model_mem.delete();
        model_ovf = 0;
        chk("rec_active_on", {31'b0, rec_active}, 32'd1);
        chk("frames_cleared", {28'b0, frames}, 32'd0);
        for (int i = 0; i < n; i++) begin
            LVBL = 1'b1;
            junk_inputs();
            tick(2);
            if (fixed) begin
                game_coin  = 4'b1110;
                game_start = 4'b1101;
                game_joy1  = 10'h3FE;
                w          = 16'h0019;
            end else begin
                junk_inputs();
                w = model_word(game_coin, game_start, game_joy1);
            end
            LVBL = 1'b0;
            if (model_mem.size() < Cap) model_mem.push_back(w);
            else model_ovf = 1;
            tick(1);
            junk_inputs();
            chk("frames_step", {28'b0, frames}, model_mem.size());
            chk("full_step", {31'b0, full}, (model_mem.size() == Cap) ? 32'd1 : 32'd0);
            chk("ovf_step", {31'b0, overflow}, {31'b0, model_ovf});
            tick(1);
        end
        if (!keep_en) begin
            rec_en = 1'b0;
            tick(2);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0,1; mode 2: random ready
    task automatic dump(input int mode);
        int    cyc;
        int    first;
        int    lastc;
        int    n;
        logic  [3:0] pat;
        pat = 4'b1001;
        n   = model_mem.size();
        for (int i = 0; i < n; i++) exp_q.push_back({model_mem[i], (i == n - 1)});
        dump_ready = (mode == 0);
        dump_start = 1'b1;
        tick(1);
        dump_start = 1'b0;
        cyc   = 0;
        first = -1;
        lastc = -1;
        while (exp_q.size() != 0 && cyc < 200) begin
            if (mode == 1) dump_ready = pat[3 - (cyc % 4)];
            else if (mode == 2) dump_ready = 1'($urandom);
            @(negedge clk);
            if (dump_valid && dump_ready) begin
                if (first < 0) first = cyc;
                lastc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("dump_timeout", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
        chk("dump_valid_drop", {31'b0, dump_valid}, 32'd0);
        if (mode == 0) begin
            chk("dump_consecutive", lastc - first, n - 1);
            chk("dump_latency", (first >= 1) ? 32'd1 : 32'd0, 32'd1);
        end
        dump_ready = 1'b0;
        tick(2);
        chk("dump_idle_valid", {31'b0, dump_valid}, 32'd0);
        exp_q.delete();
    endtask

    task automatic expect_no_dump();
        int seen;
        seen       = 0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick(1);
        dump_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dump_valid) seen++;
        end
        chk("no_dump_when_empty", seen, 0);
        dump_ready = 1'b0;
        tick(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int c;
        rst_n       = 1'b0;
        LVBL        = 1'b1;
        downloading = 1'b0;
        rec_en      = 1'b0;
        dump_start  = 1'b0;
        dump_ready  = 1'b0;
        game_coin   = 4'hF;
        game_start  = 4'hF;
        game_joy1   = 10'h3FF;
        tick(3);
        chk("rst_dump_valid", {31'b0, dump_valid}, 32'd0);
        chk("rst_dump_data", {16'b0, dump_data}, 32'd0);
        chk("rst_dump_last", {31'b0, dump_last}, 32'd0);
        chk("rst_rec_active", {31'b0, rec_active}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_frames", {28'b0, frames}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Dump request with nothing recorded
        expect_no_dump();

        // Fixed active-low pattern, three frames of 16'h0019
        record(3, 1'b1, 1'b0);
        chk("t1_frames", {28'b0, frames}, 32'd3);
        chk("t1_rec_idle", {31'b0, rec_active}, 32'd0);
        dump(0);

        // Five random frames, full-rate dump, then a re-dump with stalls
        record(5, 1'b0, 1'b0);
        chk("t3_frames", {28'b0, frames}, 32'd5);
        dump(0);
        dump(1);
        dump(2);

        // Fill past capacity and dump from FULL with rec_en still high
        record(Cap + 2, 1'b0, 1'b1);
        chk("t2_full", {31'b0, full}, 32'd1);
        chk("t2_frames", {28'b0, frames}, Cap);
        chk("t2_overflow", {31'b0, overflow}, 32'd1);
        dump(0);
        tick(4);
        chk("t2_no_restart", {31'b0, rec_active}, 32'd0);
        chk("t2_frames_kept", {28'b0, frames}, Cap);
        chk("t2_ovf_kept", {31'b0, overflow}, 32'd1);
        rec_en = 1'b0;
        tick(2);
        rec_en = 1'b1;
        tick(2);
        chk("t2_restart", {31'b0, rec_active}, 32'd1);
        chk("t2_restart_frames", {28'b0, frames}, 32'd0);
        chk("t2_restart_ovf", {31'b0, overflow}, 32'd0);
        rec_en = 1'b0;
        tick(2);

        // Download aborts recording, frames kept, later frame edges ignored
        record(3, 1'b0, 1'b1);
        downloading = 1'b1;
        tick(2);
        chk("t5_rec_off", {31'b0, rec_active}, 32'd0);
        chk("t5_frames", {28'b0, frames}, 32'd3);
        LVBL = 1'b1;
        tick(2);
        LVBL = 1'b0;
        tick(2);
        chk("t5_frames_no_write", {28'b0, frames}, 32'd3);
        rec_en = 1'b0;
        tick(1);
        downloading = 1'b0;
        tick(2);
        dump(2);

        // Reset in the middle of a dump
        record(6, 1'b0, 1'b0);
        for (int i = 0; i < model_mem.size(); i++)
            exp_q.push_back({model_mem[i], (i == model_mem.size() - 1)});
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick(1);
        dump_start = 1'b0;
        base = xfers;
        c    = 0;
        while (xfers < base + 2 && c < 50) begin
            tick(1);
            c++;
        end
        chk("t6_reached_mid_dump", (c < 50) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'b0, dump_valid}, 32'd0);
        chk("t6_async_frames", {28'b0, frames}, 32'd0);
        exp_q.delete();
        model_mem.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        expect_no_dump();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
